// File: rtl/stream_pkg.sv
// Shared types and constants for the packet-stream arbiter/mux family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stream_pkg;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   // Index of the set bit in a one-hot vector of up to 16 bits.
   function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready FIFO with occupancy count.
// Latency: an entry pushed into an empty buffer is at the head the next cycle.
// Backpressure: in_rdy depends on the registered count only; full at 2 entries.
module stream_skid_buf #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         push;
   logic         pop;

   assign in_rdy  = (count < 2'd2);
   assign out_vld = (count != 2'd0);
   assign out_dat = mem[rd_ptr];
   assign push    = in_vld & in_rdy;
   assign pop     = out_vld & out_rdy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/stream_arb_mux.sv
// N-input packet-atomic arbiter/mux (round-robin or fixed priority) onto one stream.
// Latency: grant one cycle after request; accepted beat is on m_* next cycle if buffer empty.
// Backpressure: s_ready follows the registered buffer count; 2 beats absorbed after m_ready drops.
module stream_arb_mux
   import stream_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int DATA_W   = 8,
   parameter int ARB_MODE = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_CH*DATA_W-1:0] s_data,
   input  logic [N_CH-1:0]        s_valid,
   input  logic [N_CH-1:0]        s_last,
   output logic [N_CH-1:0]        s_ready,
   output logic [DATA_W-1:0]      m_data,
   output logic                   m_valid,
   output logic                   m_last,
   input  logic                   m_ready,
   output logic [N_CH-1:0]        grant,
   output logic                   busy
);

   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   arb_state_t        state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  g_idx;
   logic [N_CH-1:0]   hi_mask;
   logic [N_CH-1:0]   req_hi;
   logic [N_CH-1:0]   nxt_grant;
   logic [DATA_W-1:0] sel_data;
   logic              sel_valid;
   logic              sel_last;
   logic              buf_in_rdy;
   logic              acc;
   logic [1:0]        buf_count;
   logic [DATA_W:0]   buf_out;

   function automatic logic [N_CH-1:0] lowest(input logic [N_CH-1:0] v);
      return v & (~v + N_CH'(1));
   endfunction

   // Round-robin: prefer requests at or above rr_ptr, otherwise wrap to the lowest.
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < N_CH; i++) hi_mask[i] = (i >= int'(rr_ptr));
      req_hi = s_valid & hi_mask;
      if (ARB_MODE == ARB_FIXED) nxt_grant = lowest(s_valid);
      else if (|req_hi)          nxt_grant = lowest(req_hi);
      else                       nxt_grant = lowest(s_valid);
   end

   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant[i]) begin
            sel_data  = s_data[i*DATA_W +: DATA_W];
            sel_valid = s_valid[i];
            sel_last  = s_last[i];
         end
      end
   end

   assign s_ready = grant & {N_CH{buf_in_rdy}};
   assign acc     = sel_valid & buf_in_rdy;
   assign g_idx   = IDX_W'(onehot_to_idx(16'(grant)));
   assign busy    = (state == LOCK) || (buf_count != 2'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|s_valid) begin
                  grant <= nxt_grant;
                  state <= LOCK;
               end
            end
            LOCK: begin
               if (acc && sel_last) begin
                  grant <= '0;
                  state <= IDLE;
                  if (ARB_MODE == ARB_RR)
                     rr_ptr <= (g_idx == IDX_W'(N_CH - 1)) ? '0 : g_idx + IDX_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   stream_skid_buf #(.W(DATA_W + 1)) u_buf (
      .clk     (clk),
      .reset   (reset),
      .in_vld  (sel_valid),
      .in_rdy  (buf_in_rdy),
      .in_dat  ({sel_last, sel_data}),
      .out_vld (m_valid),
      .out_rdy (m_ready),
      .out_dat (buf_out),
      .count   (buf_count)
   );

   assign m_last = buf_out[DATA_W];
   assign m_data = buf_out[DATA_W-1:0];

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux: one round-robin and one fixed-priority instance.
// Latency: n/a. Backpressure: bench drives m_ready directly.
// Sources are per-channel beat queues; outputs are collected and compared to hand-written lists.
module tb_stream_arb_mux;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [N*W-1:0] s_data;
   logic [N-1:0]   s_valid;
   logic [N-1:0]   s_last;
   logic           m_ready;
   logic           use_fp;

   logic [N-1:0] rr_valid, fp_valid;
   logic [N-1:0] rr_s_ready, fp_s_ready, rr_grant, fp_grant;
   logic [W-1:0] rr_m_data, fp_m_data;
   logic         rr_m_valid, fp_m_valid, rr_m_last, fp_m_last, rr_busy, fp_busy;

   logic [N-1:0] o_s_ready, o_grant;
   logic [W-1:0] o_m_data;
   logic         o_m_valid, o_m_last, o_busy;

   logic [8:0]   srcq [N][$];
   logic [8:0]   outq [$];
   int           glog [$];
   logic [N-1:0] prev_grant = '0;
   bit           hold [N];
   int           checks = 0;
   int           failures = 0;

   assign rr_valid  = use_fp ? '0 : s_valid;
   assign fp_valid  = use_fp ? s_valid : '0;
   assign o_s_ready = use_fp ? fp_s_ready : rr_s_ready;
   assign o_grant   = use_fp ? fp_grant   : rr_grant;
   assign o_m_data  = use_fp ? fp_m_data  : rr_m_data;
   assign o_m_valid = use_fp ? fp_m_valid : rr_m_valid;
   assign o_m_last  = use_fp ? fp_m_last  : rr_m_last;
   assign o_busy    = use_fp ? fp_busy    : rr_busy;

   stream_arb_mux #(.N_CH(N), .DATA_W(W), .ARB_MODE(0)) dut_rr (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(rr_valid), .s_last(s_last),
      .s_ready(rr_s_ready), .m_data(rr_m_data), .m_valid(rr_m_valid), .m_last(rr_m_last),
      .m_ready(m_ready), .grant(rr_grant), .busy(rr_busy)
   );

   stream_arb_mux #(.N_CH(N), .DATA_W(W), .ARB_MODE(1)) dut_fp (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(fp_valid), .s_last(s_last),
      .s_ready(fp_s_ready), .m_data(fp_m_data), .m_valid(fp_m_valid), .m_last(fp_m_last),
      .m_ready(m_ready), .grant(fp_grant), .busy(fp_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int oh_idx(input logic [N-1:0] oh);
      int r = -1;
      for (int i = 0; i < N; i++) if (oh[i]) r = i;
      return r;
   endfunction

   task automatic drive();
      logic [8:0] h;
      for (int c = 0; c < N; c++) begin
         if (!hold[c] && srcq[c].size() > 0) begin
            h = srcq[c][0];
            s_valid[c] = 1'b1;
            s_last[c]  = h[8];
            s_data[c*W +: W] = h[7:0];
         end else begin
            s_valid[c] = 1'b0;
            s_last[c]  = 1'b0;
            s_data[c*W +: W] = '0;
         end
      end
   endtask

   // One clock: present inputs, note handshakes, advance to 1 time unit past the edge.
   task automatic step();
      logic [N-1:0] acc;
      drive();
      acc = s_valid & o_s_ready;
      if (o_m_valid && m_ready) outq.push_back({o_m_last, o_m_data});
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) if (acc[c]) void'(srcq[c].pop_front());
      if (o_grant != '0 && prev_grant == '0) glog.push_back(oh_idx(o_grant));
      prev_grant = o_grant;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() != 0
              || o_m_valid || o_busy) && n < 200) begin
         step();
         n++;
      end
      chk({tag, "_drain_in_budget"}, 32'(n < 200), 32'd1);
   endtask

   task automatic chk_out(input string tag, input logic [8:0] exp[$]);
      chk({tag, "_out_len"}, 32'(outq.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         chk($sformatf("%s_out[%0d]", tag, i),
             (i < outq.size()) ? 32'(outq[i]) : 32'hDEAD, 32'(exp[i]));
   endtask

   task automatic chk_glog(input string tag, input int exp[$]);
      chk({tag, "_grant_cnt"}, 32'(glog.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         chk($sformatf("%s_grant[%0d]", tag, i),
             (i < glog.size()) ? 32'(glog[i]) : 32'hDEAD, 32'(exp[i]));
   endtask

   task automatic clear_logs();
      outq.delete();
      glog.delete();
   endtask

   initial begin
      reset = 1'b1; m_ready = 1'b1; use_fp = 1'b0;
      s_data = '0; s_valid = '0; s_last = '0;
      for (int c = 0; c < N; c++) hold[c] = 1'b0;
      repeat (2) step();
      chk("rst_s_ready", 32'(o_s_ready), 32'h0);
      chk("rst_grant",   32'(o_grant),   32'h0);
      chk("rst_m_valid", 32'(o_m_valid), 32'h0);
      chk("rst_m_last",  32'(o_m_last),  32'h0);
      chk("rst_m_data",  32'(o_m_data),  32'h0);
      chk("rst_busy",    32'(o_busy),    32'h0);
      reset = 1'b0;
      step();
      chk("idle_busy", 32'(o_busy), 32'h0);

      // Single-beat packet on channel 2 moves rr_ptr to 3.
      clear_logs();
      srcq[2].push_back({1'b1, 8'h99});
      drain("pre");
      chk_out("pre", '{ {1'b1, 8'h99} });

      // Reset in the middle of a 3-beat packet on channel 2.
      clear_logs();
      srcq[2].push_back({1'b0, 8'hA0});
      srcq[2].push_back({1'b0, 8'hA1});
      srcq[2].push_back({1'b1, 8'hA2});
      step();
      chk("lat_grant",   32'(o_grant),   32'h4);
      chk("lat_s_ready", 32'(o_s_ready), 32'h4);
      chk("lat_m_valid", 32'(o_m_valid), 32'h0);
      step();
      chk("lat_m_valid1", 32'(o_m_valid), 32'h1);
      chk("lat_m_data1",  32'(o_m_data),  32'hA0);
      step();
      chk("mid_m_data", 32'(o_m_data), 32'hA1);
      reset = 1'b1;
      #1;
      chk("midrst_grant",   32'(o_grant),   32'h0);
      chk("midrst_s_ready", 32'(o_s_ready), 32'h0);
      chk("midrst_m_valid", 32'(o_m_valid), 32'h0);
      chk("midrst_m_data",  32'(o_m_data),  32'h0);
      chk("midrst_busy",    32'(o_busy),    32'h0);
      srcq[2].delete();
      step();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("postrst_m_valid%0d", k), 32'(o_m_valid), 32'h0);
      end
      srcq[0].push_back({1'b1, 8'h01});
      srcq[3].push_back({1'b1, 8'h03});
      step();
      chk("postrst_rr_ptr0_grant", 32'(o_grant), 32'h1);
      drain("rst");
      chk_out("rst", '{ {1'b0, 8'hA0}, {1'b1, 8'h01}, {1'b1, 8'h03} });
      chk_glog("rst", '{2, 0, 3});

      // Round-robin fairness: all channels request 2-beat packets.
      clear_logs();
      srcq[0].push_back({1'b0, 8'h00}); srcq[0].push_back({1'b1, 8'h01});
      srcq[0].push_back({1'b0, 8'h02}); srcq[0].push_back({1'b1, 8'h03});
      srcq[1].push_back({1'b0, 8'h10}); srcq[1].push_back({1'b1, 8'h11});
      srcq[2].push_back({1'b0, 8'h20}); srcq[2].push_back({1'b1, 8'h21});
      srcq[3].push_back({1'b0, 8'h30}); srcq[3].push_back({1'b1, 8'h31});
      drain("rr");
      chk_glog("rr", '{0, 1, 2, 3, 0});
      chk_out("rr", '{ {1'b0, 8'h00}, {1'b1, 8'h01}, {1'b0, 8'h10}, {1'b1, 8'h11},
                       {1'b0, 8'h20}, {1'b1, 8'h21}, {1'b0, 8'h30}, {1'b1, 8'h31},
                       {1'b0, 8'h02}, {1'b1, 8'h03} });

      // Fixed priority: channel 1 keeps winning while it has packets.
      clear_logs();
      use_fp = 1'b1;
      srcq[1].push_back({1'b0, 8'h40}); srcq[1].push_back({1'b1, 8'h41});
      srcq[1].push_back({1'b1, 8'h42});
      srcq[3].push_back({1'b0, 8'h70}); srcq[3].push_back({1'b1, 8'h71});
      step();
      chk("fp_first_grant", 32'(o_grant), 32'h2);
      drain("fp");
      chk_glog("fp", '{1, 1, 3});
      chk_out("fp", '{ {1'b0, 8'h40}, {1'b1, 8'h41}, {1'b1, 8'h42},
                       {1'b0, 8'h70}, {1'b1, 8'h71} });
      use_fp = 1'b0;

      // Backpressure: m_ready low for 5 cycles during a 6-beat packet on channel 1.
      clear_logs();
      for (int b = 0; b < 6; b++) srcq[1].push_back({(b == 5), 8'(8'h10 + b)});
      step();
      chk("bp_grant", 32'(o_grant), 32'h2);
      m_ready = 1'b0;
      step();
      chk("bp_m_data_first", 32'(o_m_data), 32'h10);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("bp_hold_m_data%0d", k), 32'(o_m_data), 32'h10);
         chk($sformatf("bp_s_ready%0d", k), 32'(o_s_ready), 32'h0);
      end
      chk("bp_two_accepted", 32'(srcq[1].size()), 32'd4);
      chk("bp_m_valid", 32'(o_m_valid), 32'h1);
      chk("bp_m_last",  32'(o_m_last),  32'h0);
      chk("bp_busy",    32'(o_busy),    32'h1);
      m_ready = 1'b1;
      drain("bp");
      chk_out("bp", '{ {1'b0, 8'h10}, {1'b0, 8'h11}, {1'b0, 8'h12},
                       {1'b0, 8'h13}, {1'b0, 8'h14}, {1'b1, 8'h15} });

      // Back-to-back single-beat packets; rr_ptr=2 so channel 0 wins by wrap-around.
      clear_logs();
      srcq[0].push_back({1'b1, 8'h55});
      srcq[1].push_back({1'b1, 8'h66});
      step();
      chk("sb_grant0", 32'(o_grant), 32'h1);
      step();
      chk("sb_idle_grant", 32'(o_grant),   32'h0);
      chk("sb_idle_ready", 32'(o_s_ready), 32'h0);
      chk("sb_m_data0",    32'(o_m_data),  32'h55);
      chk("sb_m_last0",    32'(o_m_last),  32'h1);
      step();
      chk("sb_grant1", 32'(o_grant), 32'h2);
      step();
      chk("sb_m_data1", 32'(o_m_data), 32'h66);
      chk("sb_m_last1", 32'(o_m_last), 32'h1);
      drain("sb");
      chk_out("sb", '{ {1'b1, 8'h55}, {1'b1, 8'h66} });

      // Mid-packet stall on channel 2 while channel 3 requests.
      clear_logs();
      srcq[2].push_back({1'b0, 8'hB0}); srcq[2].push_back({1'b0, 8'hB1});
      srcq[2].push_back({1'b1, 8'hB2});
      srcq[3].push_back({1'b0, 8'hC0}); srcq[3].push_back({1'b1, 8'hC1});
      step();
      chk("st_grant", 32'(o_grant), 32'h4);
      step();
      hold[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("st_hold_grant%0d", k), 32'(o_grant), 32'h4);
      end
      chk("st_no_accept", 32'(srcq[2].size()), 32'd2);
      hold[2] = 1'b0;
      drain("st");
      chk_glog("st", '{2, 3});
      chk_out("st", '{ {1'b0, 8'hB0}, {1'b0, 8'hB1}, {1'b1, 8'hB2},
                       {1'b0, 8'hC0}, {1'b1, 8'hC1} });

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stream_arb_mux.md
# stream_arb_mux

Parametrised N-input packet-stream arbiter/multiplexer with valid/ready/last handshakes on every port. It replaces the fixed two-input, externally selected mux: selection is now internal, either round-robin or fixed priority, and packet-atomic (a grant holds until the beat carrying `last` is accepted). A two-entry output buffer provides full-rate throughput under master backpressure. It sits between several packet producers and one downstream stream consumer.

## Interface
- `N_CH`, default 4: number of slave channels (2..16).
- `DATA_W`, default 8: data width per beat.
- `ARB_MODE`, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_data`  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- `s_valid`  in  N_CH  per-channel beat valid.
- `s_last`  in  N_CH  per-channel end-of-packet marker.
- `s_ready`  out  N_CH  per-channel ready; at most one bit high.
- `m_data`  out  DATA_W  output beat.
- `m_valid`  out  1  output beat valid.
- `m_last`  out  1  output end-of-packet marker.
- `m_ready`  in  1  downstream ready.
- `grant`  out  N_CH  one-hot current owner; all zero when idle.
- `busy`  out  1  high while in LOCK or while the output buffer is non-empty.

## Operation
- A beat transfers on any port when valid and ready are both high at a rising edge.
- FSM states: IDLE and LOCK.
- IDLE: `s_ready` is all zero. When any `s_valid` bit is high, the arbiter registers a one-hot `grant` and moves to LOCK. No request keeps the FSM in IDLE.
- Round-robin search starts at pointer `rr_ptr` and wraps modulo N_CH. Fixed priority picks the lowest set index.
- LOCK: `s_ready[g] = (buf_count < 2)`; all other bits are 0. `s_valid` deasserting mid-packet keeps the lock, and the arbiter waits.
- When a beat with `s_last` is accepted in LOCK, the FSM returns to IDLE, `grant` clears, and `rr_ptr` becomes (g+1) mod N_CH. `rr_ptr` is unchanged in fixed-priority mode.
- The output buffer is a FIFO holding {data, last} with count 0..2.
  - m_valid = (count != 0).
  - m_data and m_last come from the head entry.
  - Simultaneous push and pop leaves count unchanged.
  - Entries are never overwritten while m_valid is high and m_ready is low; m_data and m_last stay stable.
- Beats are never dropped, duplicated, reordered, or interleaved across packets.
- A single-beat packet (valid and last on the first beat) is legal: LOCK lasts one cycle.

## Timing
- Reset values: state IDLE, rr_ptr 0, buffer count 0, `s_ready` 0, `grant` 0, `m_valid` 0, `m_last` 0, `m_data` 0, `busy` 0.
- Grant latency: s_valid rises at edge t; grant and s_ready are high after edge t+1. The first beat is accepted at edge t+2 if the buffer count is below 2.
- Data latency: a beat accepted at edge k appears on m_* after edge k when the buffer was empty.
- Throughput: one beat per cycle inside a packet while m_ready stays high. There is one idle input cycle between packets, which the buffer may hide on the output side.
- Backpressure:
  - With m_ready low, at most 2 beats are accepted after the last pop; s_ready then drops.
  - s_ready reflects the registered count only (no combinational m_ready-to-s_ready path).
- A new request arriving in the same cycle as the last-beat acceptance is considered in the following IDLE cycle.
- Reset asserted mid-packet immediately forces reset values. Buffered beats are discarded, and the partial packet is not completed.

## Structure
- Shared package `stream_pkg`:
  - `ARB_RR` / `ARB_FIXED` constants.
  - `arb_state_t` enum {IDLE, LOCK}.
  - A helper function for one-hot to index conversion.
- Sub-module `stream_skid_buf`: parametrised DATA_W+1 wide, 2-entry FIFO with in/out valid-ready and a count output. The top level holds the FSM, arbiter, and input mux.

## Test plan
- Reset mid-packet:
  - Stimulus: with N_CH=4, channel 2 sends 3 beats (0xA0, 0xA1, 0xA2 with last); assert reset after beat 1.
  - Required response: all outputs 0 within the reset; after release, rr_ptr=0 and m_valid=0 until a new request.
- Round-robin fairness:
  - Stimulus: channels 0–3 all hold valid, each sending 2-beat packets.
  - Required response: grants in order 0,1,2,3,0; m_data packets are never interleaved.
- Fixed priority (ARB_MODE=1):
  - Stimulus: channels 1 and 3 both requesting.
  - Required response: channel 1 is always served first; channel 3 is served only after channel 1 goes idle.
- Backpressure:
  - Stimulus: hold m_ready low for 5 cycles during a 6-beat packet 0x10..0x15.
  - Required response: exactly 2 beats are buffered; s_ready drops; m_data holds 0x10 stable; all 6 beats arrive in order with m_last only on 0x15.
- Single-beat packets:
  - Stimulus: back-to-back single-beat packets on channel 0 (0x55) and channel 1 (0x66).
  - Required response: each m_last=1; one idle input cycle between grants.
- Mid-packet stall:
  - Stimulus: granted channel drops s_valid for 3 cycles mid-packet while other channels request.
  - Required response: grant stays unchanged; no foreign beats appear.
